// File: rtl/gf180mcu_fd_sc_mcu7t5v0__subf_serial.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor slice plus a borrow flop, LSB first.
// Define GF180MCU_FD_SC_MCU7T5V0__SUBF_SERIAL_OV_EN to add the signed-overflow output OV.
module gf180mcu_fd_sc_mcu7t5v0__subf_serial #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BI,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BO,
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBF_SERIAL_OV_EN
    output logic             OV,
`endif
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             brw_nxt;
    logic             bit_d;
    logic             capture;
    logic             last;

    // Handshake: START is accepted only in IDLE or DONE; while BUSY it is ignored.
    assign capture = START && ((state == S_IDLE) || (state == S_DONE));
    assign last    = (state == S_RUN) && (cnt == CW'(WIDTH - 1));

    // Full-subtractor slice on the current LSBs.
    always_comb begin
        bit_d   = a_sh[0] ^ b_sh[0] ^ brw;
        brw_nxt = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & brw) | (b_sh[0] & brw);
        res_nxt = WIDTH'({bit_d, res_sh} >> 1);
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (START) state_nxt = S_RUN;
            S_RUN:   if (last) state_nxt = S_DONE;
            S_DONE:  state_nxt = START ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY      = (state == S_RUN);
        DONE      = (state == S_DONE);
        dbg_state = state;
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            D      <= '0;
            BO     <= 1'b0;
        end else if (capture) begin
            a_sh   <= A;
            b_sh   <= B;
            res_sh <= '0;
            brw    <= BI;
            cnt    <= '0;
        end else if (state == S_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nxt;
            brw    <= brw_nxt;
            cnt    <= cnt + CW'(1);
            if (last) begin
                D  <= res_nxt;
                BO <= brw_nxt;
            end
        end
    end

`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBF_SERIAL_OV_EN
    // On the MSB step brw is the borrow into the MSB and brw_nxt the borrow out of it.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN)       OV <= 1'b0;
        else if (last) OV <= brw ^ brw_nxt;
    end
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__subf_serial.sv
// Self-checking bench for the bit-serial subtractor (WIDTH=8 main instance, WIDTH=1 corner instance).
module tb_gf180mcu_fd_sc_mcu7t5v0__subf_serial;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RN;
    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         BI;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] D;
    logic         BO;
    logic         OV;
    logic [1:0]   dbg_state;

    logic         start1;
    logic         a1;
    logic         b1;
    logic         bi1;
    logic         busy1;
    logic         done1;
    logic         d1;
    logic         bo1;
    logic         ov1;
    logic [1:0]   dbg_state1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_bo_q[$];
    logic         exp_ov_q[$];
    logic [W-1:0] prev_d;
    logic         prev_bo;

    // ---------------- clock / reset / DUTs ----------------
    always #5 CLK = ~CLK;

    gf180mcu_fd_sc_mcu7t5v0__subf_serial #(.WIDTH(W)) u_dut (
        .CLK(CLK), .RN(RN), .START(START), .A(A), .B(B), .BI(BI),
        .BUSY(BUSY), .DONE(DONE), .D(D), .BO(BO),
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBF_SERIAL_OV_EN
        .OV(OV),
`endif
        .dbg_state(dbg_state)
    );

    gf180mcu_fd_sc_mcu7t5v0__subf_serial #(.WIDTH(1)) u_dut1 (
        .CLK(CLK), .RN(RN), .START(start1), .A(a1), .B(b1), .BI(bi1),
        .BUSY(busy1), .DONE(done1), .D(d1), .BO(bo1),
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBF_SERIAL_OV_EN
        .OV(ov1),
`endif
        .dbg_state(dbg_state1)
    );

`ifndef GF180MCU_FD_SC_MCU7T5V0__SUBF_SERIAL_OV_EN
    assign OV  = 1'b0;
    assign ov1 = 1'b0;
`endif

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model: {ov, bo, d} from plain integer arithmetic ----------------
    function automatic logic [33:0] model(input longint a, input longint b, input longint bi, input int w);
        longint m, diff, dm, sa, sb, sd;
        logic   bo, ov;
        m    = longint'(1) << w;
        diff = a - b - bi;
        dm   = (diff < 0) ? diff + m : diff;
        bo   = (diff < 0);
        sa   = (a >= m / 2) ? a - m : a;
        sb   = (b >= m / 2) ? b - m : b;
        sd   = sa - sb - bi;
        ov   = (sd < -(m / 2)) || (sd > (m / 2) - 1);
        return {ov, bo, dm[31:0]};
    endfunction

    // ---------------- driver tasks (entered and left at a negedge) ----------------
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                          input bit hold, input logic [W-1:0] na, input logic [W-1:0] nb);
        logic [33:0] r;
        START = 1'b1; A = a; B = b; BI = bi;
        r = model(longint'(a), longint'(b), longint'(bi), W);
        exp_q.push_back(r[W-1:0]);
        exp_bo_q.push_back(r[32]);
        exp_ov_q.push_back(r[33]);
        @(posedge CLK);
        @(negedge CLK);
        if (hold) begin
            A = na; B = nb; BI = ~bi;
        end else begin
            START = 1'b0;
        end
        for (int i = 0; i < W; i++) begin
            check("busy_run", BUSY, 1'b1);
            check("done_run", DONE, 1'b0);
            check("d_hold", D, prev_d);
            check("bo_hold", BO, prev_bo);
            @(negedge CLK);
        end
        check("busy_done", BUSY, 1'b0);
        check("done_pulse", DONE, 1'b1);
        check("d", D, exp_q.pop_front());
        prev_d = D;
        check("bo", BO, exp_bo_q.pop_front());
        prev_bo = BO;
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBF_SERIAL_OV_EN
        check("ov", OV, exp_ov_q.pop_front());
`else
        void'(exp_ov_q.pop_front());
`endif
    endtask

    task automatic idle(input int n);
        START = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check("done_idle", DONE, 1'b0);
            check("busy_idle", BUSY, 1'b0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [33:0] r1;
        RN = 1'b0; START = 1'b0; A = '0; B = '0; BI = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bi1 = 1'b0;
        prev_d = '0; prev_bo = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_busy", BUSY, 1'b0);
        check("rst_done", DONE, 1'b0);
        check("rst_d", D, '0);
        check("rst_bo", BO, 1'b0);
        check("rst_ov", OV, 1'b0);
        check("rst_busy1", busy1, 1'b0);
        RN = 1'b1;

        // directed cases
        run_op(8'h05, 8'h03, 1'b0, 0, '0, '0);
        idle(1);

        // abort mid-run: reset after the 4th RUN edge
        START = 1'b1; A = 8'h33; B = 8'h11; BI = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(negedge CLK);
        RN = 1'b0;
        #1;
        check("abort_busy", BUSY, 1'b0);
        check("abort_done", DONE, 1'b0);
        check("abort_d", D, '0);
        check("abort_bo", BO, 1'b0);
        check("abort_ov", OV, 1'b0);
        prev_d = '0; prev_bo = 1'b0;
        @(negedge CLK);
        RN = 1'b1;
        idle(W + 3);
        run_op(8'h09, 8'h04, 1'b0, 0, '0, '0);
        idle(1);

        run_op(8'h00, 8'h01, 1'b0, 0, '0, '0);
        run_op(8'h10, 8'h10, 1'b1, 0, '0, '0);
        idle(2);
        // START held through RUN with changing operands, then back-to-back in DONE
        run_op(8'h20, 8'h01, 1'b0, 1, 8'hFF, 8'hFF);
        run_op(8'hFF, 8'hFF, 1'b0, 0, '0, '0);
        idle(1);
        run_op(8'h80, 8'h01, 1'b0, 0, '0, '0);
        run_op(8'h7F, 8'h01, 1'b0, 0, '0, '0);
        run_op(8'h00, 8'hFF, 1'b1, 0, '0, '0);
        idle(1);

        // randomized operations with random gaps and START noise
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0), W'($urandom), W'($urandom));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(1);

        // WIDTH=1 instance: every single full-subtractor evaluation
        for (int k = 0; k < 8; k++) begin
            a1 = k[2]; b1 = k[1]; bi1 = k[0]; start1 = 1'b1;
            r1 = model(longint'(a1), longint'(b1), longint'(bi1), 1);
            @(posedge CLK);
            @(negedge CLK);
            start1 = 1'b0;
            check("w1_busy", busy1, 1'b1);
            check("w1_done_run", done1, 1'b0);
            @(negedge CLK);
            check("w1_busy_done", busy1, 1'b0);
            check("w1_done", done1, 1'b1);
            check("w1_d", d1, r1[0]);
            check("w1_bo", bo1, r1[32]);
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBF_SERIAL_OV_EN
            check("w1_ov", ov1, r1[33]);
`endif
            @(negedge CLK);
            check("w1_idle", done1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
